// File: rtl/core_inst_pkg.sv
// Shared definitions for the core instruction sequencer: inst field positions,
// the idle instruction word and the sequencer FSM states.
package core_inst_pkg;

    localparam int unsigned InstW = 34;
    localparam int unsigned AddrW = 11;

    localparam int unsigned InstAcc         = 33;
    localparam int unsigned InstPsumCen     = 32;
    localparam int unsigned InstPsumWen     = 31;
    localparam int unsigned InstPsumAddrLsb = 20;
    localparam int unsigned InstXmemCen     = 19;
    localparam int unsigned InstXmemWen     = 18;
    localparam int unsigned InstXmemAddrLsb = 7;
    localparam int unsigned InstOfifoRd     = 6;
    localparam int unsigned InstIfifoWr     = 5;
    localparam int unsigned InstIfifoRd     = 4;
    localparam int unsigned InstL0Rd        = 3;
    localparam int unsigned InstL0Wr        = 2;
    localparam int unsigned InstExec        = 1;
    localparam int unsigned InstLoad        = 0;

    // Both SRAMs disabled, no strobes, addresses 0, mode bit 0.
    localparam logic [InstW-1:0] InstIdle = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        StIdle,
        StWL0,
        StWPe,
        StAL0,
        StExec,
        StDrain,
        StDone
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/core_inst_sequencer.sv
// Generates the 34-bit core instruction stream for one weight-stationary
// convolution pass (weight load, activation fetch, execute, psum drain per kij).
module core_inst_sequencer
    import core_inst_pkg::*;
#(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned len_kij = 9,
    parameter int unsigned len_nij = 36,
    parameter int unsigned addr_w  = AddrW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [addr_w-1:0] w_base,
    input  logic [addr_w-1:0] a_base,
    input  logic [addr_w-1:0] p_base,
    output logic [InstW-1:0]  inst,
    output logic              busy,
    output logic              done,
    output logic [3:0]        kij_idx
);

    localparam int unsigned MaxLen = max_u(max_u(col + 1, col + row),
                                           max_u(len_nij + 1, len_nij + row + col));
    localparam int unsigned CntW = (MaxLen > 1) ? $clog2(MaxLen) : 1;
    localparam int unsigned OffW = addr_w - 1;

    localparam logic [CntW-1:0] ColCnt   = CntW'(col);
    localparam logic [CntW-1:0] NijCnt   = CntW'(len_nij);
    localparam logic [CntW-1:0] WPeLast  = CntW'(col + row - 1);
    localparam logic [CntW-1:0] ExecLast = CntW'(len_nij + row + col - 1);
    localparam logic [3:0]      KijLast  = 4'(len_kij - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d, last_cnt;
    logic [3:0]          kij_q, kij_d;
    logic                mode_q, mode_d;
    logic [addr_w-1:0]   w_base_q, w_base_d, a_base_q, a_base_d, p_base_q, p_base_d;
    logic [InstW-1:0]    inst_q, inst_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic                x_read;
    logic [addr_w-1:0]   x_base, x_sum;
    logic [OffW-1:0]     x_off;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        kij_d    = kij_q;
        mode_d   = mode_q;
        w_base_d = w_base_q;
        a_base_d = a_base_q;
        p_base_d = p_base_q;
        case (state_q)
            StWL0:   last_cnt = ColCnt;
            StWPe:   last_cnt = WPeLast;
            StAL0:   last_cnt = NijCnt;
            StExec:  last_cnt = ExecLast;
            StDrain: last_cnt = NijCnt;
            default: last_cnt = '0;
        endcase
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StWL0;
                    cnt_d    = '0;
                    kij_d    = '0;
                    mode_d   = mode;
                    w_base_d = w_base;
                    a_base_d = a_base;
                    p_base_d = p_base;
                end
            end
            StDone: state_d = StIdle;
            default: begin
                if (cnt_q == last_cnt) begin
                    cnt_d = '0;
                    case (state_q)
                        StWL0:  state_d = StWPe;
                        StWPe:  state_d = StAL0;
                        StAL0:  state_d = StExec;
                        StExec: state_d = StDrain;
                        StDrain: begin
                            if (kij_q == KijLast) begin
                                state_d = StDone;
                            end else begin
                                kij_d   = kij_q + 4'd1;
                                state_d = StWL0;
                            end
                        end
                        default: state_d = StIdle;
                    endcase
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    // The instruction is built from next-state values so that inst lines up
    // with state_q after the edge.
    always_comb begin
        inst_d                  = InstIdle;
        inst_d[InstXmemAddrLsb] = mode_d;
        x_read                  = 1'b0;
        x_base                  = '0;
        x_off                   = '0;
        case (state_d)
            StWL0: begin
                x_read           = cnt_d < ColCnt;
                x_base           = w_base_d;
                x_off            = OffW'(kij_d) * OffW'(col) + OffW'(cnt_d);
                inst_d[InstL0Wr] = cnt_d != '0;
            end
            StWPe: begin
                inst_d[InstL0Rd] = cnt_d < ColCnt;
                inst_d[InstLoad] = cnt_d < ColCnt;
            end
            StAL0: begin
                x_read           = cnt_d < NijCnt;
                x_base           = a_base_d;
                x_off            = OffW'(cnt_d);
                inst_d[InstL0Wr] = cnt_d != '0;
            end
            StExec: begin
                inst_d[InstL0Rd] = cnt_d < NijCnt;
                inst_d[InstExec] = cnt_d < NijCnt;
            end
            StDrain: begin
                inst_d[InstOfifoRd] = cnt_d < NijCnt;
                if (cnt_d != '0) begin
                    inst_d[InstPsumCen] = 1'b0;
                    inst_d[InstPsumWen] = 1'b0;
                    inst_d[InstPsumAddrLsb +: addr_w] = p_base_d + addr_w'(cnt_d - CntW'(1));
                    inst_d[InstAcc]     = kij_d != '0;
                end
            end
            default: ;
        endcase
        // Addresses step by 2; bit 0 is the mode bit, so the base LSB is dropped.
        x_sum = (x_base & ~addr_w'(1)) + {x_off, 1'b0};
        if (x_read) begin
            inst_d[InstXmemCen] = 1'b0;
            inst_d[InstXmemAddrLsb +: addr_w] = x_sum | addr_w'(mode_d);
        end
        busy_d = state_d != StIdle;
        done_d = state_d == StDone;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            kij_q    <= '0;
            mode_q   <= 1'b0;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            inst_q   <= InstIdle;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            kij_q    <= kij_d;
            mode_q   <= mode_d;
            w_base_q <= w_base_d;
            a_base_q <= a_base_d;
            p_base_q <= p_base_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign inst    = inst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign kij_idx = kij_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer on a small 2x2 array with a
// per-pass reference instruction listing built from the phase rules.
module tb_core_inst_sequencer;

    localparam int ROW = 2;
    localparam int COL = 2;
    localparam int KIJ = 2;
    localparam int NIJ = 4;
    localparam int PASS_CYC = KIJ * ((COL + 1) + (COL + ROW) + (NIJ + 1) + (NIJ + ROW + COL)
                                     + (NIJ + 1)) + 1;
    localparam logic [33:0] IDLE0 = 34'h1_800C_0000;

    localparam logic [6:0] S_OFRD = 7'b1000000;
    localparam logic [6:0] S_L0RD = 7'b0001000;
    localparam logic [6:0] S_L0WR = 7'b0000100;
    localparam logic [6:0] S_EXEC = 7'b0000010;
    localparam logic [6:0] S_LOAD = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset, start, mode;
    logic [10:0] w_base, a_base, p_base;
    logic [33:0] inst;
    logic        busy, done;
    logic [3:0]  kij_idx;

    int tests_run = 0;
    int tests_failed = 0;

    logic [33:0] exp_inst[$];
    int          exp_kij[$];
    int          obs_xaddr[$];
    int          obs_loads, obs_dones, obs_busy, obs_acc0, obs_acc1;

    always #5 clk = ~clk;

    core_inst_sequencer #(
        .row    (ROW),
        .col    (COL),
        .len_kij(KIJ),
        .len_nij(NIJ),
        .addr_w (11)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mode   (mode),
        .w_base (w_base),
        .a_base (a_base),
        .p_base (p_base),
        .inst   (inst),
        .busy   (busy),
        .done   (done),
        .kij_idx(kij_idx)
    );

    function automatic logic [33:0] mk(input bit m, input bit xrd, input int xa, input bit pwr,
                                       input int pa, input bit acc, input logic [6:0] strb);
        logic [33:0] w;
        w = IDLE0;
        w[7] = m;
        if (xrd) begin
            w[19]   = 1'b0;
            w[17:7] = xa[10:0];
        end
        if (pwr) begin
            w[33]    = acc;
            w[32]    = 1'b0;
            w[31]    = 1'b0;
            w[30:20] = pa[10:0];
        end
        w[6:0] = strb;
        return w;
    endfunction

    task automatic build_exp(input bit m, input int wb, input int ab, input int pb);
        exp_inst.delete();
        exp_kij.delete();
        for (int k = 0; k < KIJ; k++) begin
            for (int i = 0; i <= COL; i++) begin
                exp_inst.push_back(mk(m, i < COL, ((wb / 2 * 2) + 2 * (k * COL + i)) % 2048 + m,
                                      0, 0, 0, (i >= 1) ? S_L0WR : 7'd0));
                exp_kij.push_back(k);
            end
            for (int i = 0; i < COL + ROW; i++) begin
                exp_inst.push_back(mk(m, 0, 0, 0, 0, 0, (i < COL) ? (S_L0RD | S_LOAD) : 7'd0));
                exp_kij.push_back(k);
            end
            for (int i = 0; i <= NIJ; i++) begin
                exp_inst.push_back(mk(m, i < NIJ, ((ab / 2 * 2) + 2 * i) % 2048 + m,
                                      0, 0, 0, (i >= 1) ? S_L0WR : 7'd0));
                exp_kij.push_back(k);
            end
            for (int i = 0; i < NIJ + ROW + COL; i++) begin
                exp_inst.push_back(mk(m, 0, 0, 0, 0, 0, (i < NIJ) ? (S_L0RD | S_EXEC) : 7'd0));
                exp_kij.push_back(k);
            end
            for (int i = 0; i <= NIJ; i++) begin
                exp_inst.push_back(mk(m, 0, 0, i >= 1, (pb + i - 1) % 2048, k != 0,
                                      (i < NIJ) ? S_OFRD : 7'd0));
                exp_kij.push_back(k);
            end
        end
        exp_inst.push_back(mk(m, 0, 0, 0, 0, 0, 7'd0));
        exp_kij.push_back(-1);
    endtask

    // Pulses start at the current negedge and checks every cycle of the pass.
    // poke_at re-pulses start at that cycle index; reset_at aborts there.
    task automatic run_pass(input bit m, input int wb, input int ab, input int pb,
                            input int poke_at, input int reset_at, input string tag);
        int n;
        build_exp(m, wb, ab, pb);
        n = exp_inst.size();
        obs_xaddr.delete();
        obs_loads = 0; obs_dones = 0; obs_busy = 0; obs_acc0 = 0; obs_acc1 = 0;
        mode = m; w_base = wb[10:0]; a_base = ab[10:0]; p_base = pb[10:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = ~m; w_base = 11'($urandom); a_base = 11'($urandom); p_base = 11'($urandom);
        for (int k = 0; k < n; k++) begin
            tests_run++;
            if (inst !== exp_inst[k]) begin
                tests_failed++;
                $display("FAIL %s inst cyc %0d: got %h want %h", tag, k, inst, exp_inst[k]);
            end
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s busy cyc %0d: got %b want 1", tag, k, busy);
            end
            tests_run++;
            if (done !== (k == n - 1)) begin
                tests_failed++;
                $display("FAIL %s done cyc %0d: got %b want %b", tag, k, done, k == n - 1);
            end
            if (exp_kij[k] >= 0) begin
                tests_run++;
                if (kij_idx !== 4'(exp_kij[k])) begin
                    tests_failed++;
                    $display("FAIL %s kij cyc %0d: got %0d want %0d", tag, k, kij_idx, exp_kij[k]);
                end
            end
            if (busy === 1'b1) obs_busy++;
            if (done === 1'b1) obs_dones++;
            if (inst[0] === 1'b1) obs_loads++;
            if (inst[19] === 1'b0) obs_xaddr.push_back(int'(inst[17:7]));
            if (inst[31] === 1'b0) begin
                if (inst[33] === 1'b1) obs_acc1++;
                else obs_acc0++;
            end
            if (k == reset_at) begin
                reset = 1'b0;
                #1;
                tests_run++;
                if (inst !== IDLE0 || busy !== 1'b0 || done !== 1'b0 || kij_idx !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL %s abort: got inst %h busy %b done %b kij %0d want %h 0 0 0",
                             tag, inst, busy, done, kij_idx, IDLE0);
                end
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            start = (k == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || inst !== mk(m, 0, 0, 0, 0, 0, 7'd0)) begin
            tests_failed++;
            $display("FAIL %s post-pass: got inst %h busy %b done %b want idle 0 0",
                     tag, inst, busy, done);
        end
    endtask

    task automatic check_pass_totals(input string tag);
        tests_run++;
        if (obs_busy !== PASS_CYC) begin
            tests_failed++;
            $display("FAIL %s cycles: got %0d want %0d", tag, obs_busy, PASS_CYC);
        end
        tests_run++;
        if (obs_dones !== 1) begin
            tests_failed++;
            $display("FAIL %s done pulses: got %0d want 1", tag, obs_dones);
        end
        tests_run++;
        if (obs_acc0 !== NIJ || obs_acc1 !== NIJ * (KIJ - 1)) begin
            tests_failed++;
            $display("FAIL %s acc writes: got %0d/%0d want %0d/%0d", tag, obs_acc0, obs_acc1,
                     NIJ, NIJ * (KIJ - 1));
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; mode = 1'b0;
        w_base = '0; a_base = '0; p_base = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (inst !== IDLE0 || busy !== 1'b0 || done !== 1'b0 || kij_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset: got inst %h busy %b done %b kij %0d want %h 0 0 0",
                     inst, busy, done, kij_idx, IDLE0);
        end
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests_run++;
            if (inst !== IDLE0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle hold %0d: got inst %h busy %b want %h 0", i, inst, busy, IDLE0);
            end
        end
    endtask

    task automatic test_small_pass();
        int exp_x[12] = '{0, 2, 16, 18, 20, 22, 4, 6, 16, 18, 20, 22};
        run_pass(0, 0, 16, 0, -1, -1, "small");
        check_pass_totals("small");
        tests_run++;
        if (obs_loads !== KIJ * COL) begin
            tests_failed++;
            $display("FAIL small loads: got %0d want %0d", obs_loads, KIJ * COL);
        end
        tests_run++;
        if (obs_xaddr.size() !== 12) begin
            tests_failed++;
            $display("FAIL small xmem reads: got %0d want 12", obs_xaddr.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                tests_run++;
                if (obs_xaddr[i] !== exp_x[i]) begin
                    tests_failed++;
                    $display("FAIL small xaddr %0d: got %0d want %0d", i, obs_xaddr[i], exp_x[i]);
                end
            end
        end
    endtask

    task automatic test_mode_odd_base();
        run_pass(1, 5, 33, 100, -1, -1, "mode1");
        tests_run++;
        if (obs_xaddr.size() < 2 || obs_xaddr[0] !== 5 || obs_xaddr[1] !== 7) begin
            tests_failed++;
            $display("FAIL mode1 first xaddrs: got %0d entries, first %0d want 5,7",
                     obs_xaddr.size(), (obs_xaddr.size() > 0) ? obs_xaddr[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        run_pass(0, 40, 80, 200, 14, -1, "poke_exec");
        check_pass_totals("poke_exec");
        run_pass(1, 12, 60, 7, PASS_CYC - 1, -1, "poke_done");
        check_pass_totals("poke_done");
    endtask

    task automatic test_reset_mid_drain();
        run_pass(1, 10, 20, 30, -1, 47, "abort");
        run_pass(0, 2, 50, 300, -1, -1, "after_abort");
        check_pass_totals("after_abort");
    endtask

    task automatic test_back_to_back();
        run_pass(1, 100, 200, 64, -1, -1, "b2b_a");
        run_pass(0, 300, 400, 64, -1, -1, "b2b_b");
        check_pass_totals("b2b_b");
    endtask

    task automatic test_random();
        run_pass(0, 2046, 2040, 2046, -1, -1, "wrap");
        check_pass_totals("wrap");
        for (int r = 0; r < 4; r++) begin
            run_pass(1'($urandom), int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                     int'($urandom_range(0, 2047)), -1, -1, "random");
            check_pass_totals("random");
        end
    endtask

    initial begin
        test_reset();
        test_small_pass();
        test_mode_odd_base();
        test_start_ignored();
        test_reset_mid_drain();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
